sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Input-side conditioner for DE2 slide switches/keys: synchronises raw asynchronous pad
//  levels into clk and filters contact bounce. Emits clean levels plus one-cycle edge pulses.
//  Sits between board switch pins and all logic consuming them (LED drivers, control FSMs).
// PARAMETERS
//  N_SW        2          number of switch inputs handled (independent channels)
//  DEB_CYCLES  1000000    consecutive stable clk cycles required to accept a change (20 ms @ 50 MHz); >= 1
//  CNT_W       20         debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES-1
// PORTS
//  clk       in   1      system clock (50 MHz board clock)
//  rst_n     in   1      synchronous reset, active-low
//  sw        in   N_SW   raw switch levels, asynchronous to clk
//  sw_db     out  N_SW   debounced switch levels
//  sw_rise   out  N_SW   1-cycle pulse: sw_db bit went 0->1
//  sw_fall   out  N_SW   1-cycle pulse: sw_db bit went 1->0
//  sw_any    out  1      1-cycle pulse: OR of all sw_rise|sw_fall bits
//  evt_clr   in   N_SW   [SW_EVENT_LATCH_EN only] clear sticky event flags, per bit
//  sw_evt    out  N_SW   [SW_EVENT_LATCH_EN only] sticky "changed since last clear" flags
// BEHAVIOUR
//  - Reset (rst_n=0 sampled on clk rising edge): sync flops, counters, sw_db, sw_rise, sw_fall,
//    sw_any, sw_evt all 0. Reset is synchronous only; no async clear of any flop.
//  - Sync: 2-flop synchroniser per bit (s1 <= sw; s2 <= s1). Only s2 feeds the filter.
//  - Per-bit FSM, two states:
//    STABLE : s2 == sw_db; cnt held at 0. s2 != sw_db -> PENDING, cnt <= 1 (or accept if DEB_CYCLES==1).
//    PENDING: s2 != sw_db; cnt increments each cycle. s2 == sw_db (glitch) -> STABLE, cnt <= 0, no output.
//             cnt == DEB_CYCLES-1 and s2 still != sw_db -> sw_db <= s2, cnt <= 0, STABLE, edge pulse.
//  - Acceptance needs exactly DEB_CYCLES consecutive disagreeing s2 samples; any agreeing sample restarts.
//  - Latency: sw step held steady -> sw_db changes 2+DEB_CYCLES clk edges after first sampling edge.
//  - sw_rise/sw_fall registered, asserted in the same cycle sw_db takes its new value, high exactly 1 cycle.
//  - sw_any registered in parallel from the same next-state terms (coincident with sw_rise/sw_fall).
//  - Channels fully independent; simultaneous accepts on several bits give simultaneous pulses.
//  - Counter never wraps: cleared on accept or glitch, max value DEB_CYCLES-1.
//  - Reset mid-debounce: pending count discarded; if switch is held high through reset,
//    sw_db rises (with sw_rise pulse) 2+DEB_CYCLES cycles after rst_n returns high.
//  - sw changing faster than DEB_CYCLES: sw_db holds last accepted value indefinitely.
// CONFIGURATION
//  Macro SW_EVENT_LATCH_EN:
//  - defined: ports evt_clr/sw_evt present. sw_evt[i] set on sw_rise[i]|sw_fall[i], cleared
//    when evt_clr[i]=1; set and clear in same cycle -> set wins (flag stays 1). Reset value 0.
//    sw_evt visible one cycle after the pulse.
//  - undefined: evt_clr/sw_evt absent from port list; no sticky registers synthesised.
// TESTING (bench with N_SW=2, DEB_CYCLES=4, CNT_W=3)
//  1. rst_n=0 for 3 cycles with sw=2'b11 -> all outputs 0 during reset; after release sw_db=2'b11
//     at cycle 6, sw_rise=2'b11 and sw_any=1 for that single cycle only.
//  2. sw[0] 0->1 held -> sw_db[0]=1 exactly 6 edges later; sw_rise[0] 1 cycle; sw_fall, sw_db[1] unchanged.
//  3. sw[0] bounce 1,0,1,0 each lasting 3 cycles then steady 1 -> no pulse during bounce;
//     single sw_rise[0] 6 cycles after final steady 1.
//  4. sw[1] high for exactly 3 cycles (DEB_CYCLES-1) -> sw_db[1] stays 0, no pulses; for 4 cycles -> accepted.
//  5. Pending change, rst_n=0 asserted at count 2 -> sw_db=0, counters 0; released with sw held -> full
//     re-debounce, accept after 6 cycles.
//  6. SW_EVENT_LATCH_EN: sw[1] fall with evt_clr[1]=1 in pulse cycle -> sw_evt[1]=1 next cycle;
//     evt_clr[1]=1 later with no event -> sw_evt[1]=0 next cycle; sw_evt[0] untouched.

Source files
------------

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//  Input conditioner for board slide switches / keys. Each raw pad level is
//  brought into the clk domain through a two-flop synchroniser, then filtered
//  by a per-channel two-state debounce FSM. A change is accepted only after
//  DEB_CYCLES consecutive synchronised samples disagree with the current clean
//  level. Any agreeing sample cancels the pending change.
//
//  Optional feature: define SW_EVENT_LATCH_EN to add per-channel sticky
//  "changed since last clear" flags (sw_evt) with a per-bit clear (evt_clr).
//  When the macro is undefined, those ports and registers do not exist.
//
// Parameters
//  N_SW        number of independent switch channels
//  DEB_CYCLES  stable samples required to accept a change (>= 1)
//  CNT_W       counter width, 2**CNT_W > DEB_CYCLES-1
//
// Ports
//  clk      in   system clock
//  rst_n    in   synchronous reset, active-low
//  sw       in   raw asynchronous switch levels [N_SW]
//  sw_db    out  debounced levels [N_SW]
//  sw_rise  out  one-cycle pulse when a sw_db bit goes 0->1 [N_SW]
//  sw_fall  out  one-cycle pulse when a sw_db bit goes 1->0 [N_SW]
//  sw_any   out  one-cycle pulse, OR of all rise/fall pulses
//  evt_clr  in   per-bit sticky flag clear   (SW_EVENT_LATCH_EN only)
//  sw_evt   out  per-bit sticky event flags  (SW_EVENT_LATCH_EN only)
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int N_SW       = 2,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_any
`ifdef SW_EVENT_LATCH_EN
  ,
  input  logic [N_SW-1:0] evt_clr,
  output logic [N_SW-1:0] sw_evt
`endif
);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_SW-1:0]  sync_p0;
  logic [N_SW-1:0]  sync_p1;
  logic [N_SW-1:0]  state_q;
  logic [CNT_W-1:0] cnt_q [N_SW];

  logic [N_SW-1:0]  state_d;
  logic [CNT_W-1:0] cnt_d [N_SW];
  logic [N_SW-1:0]  db_d;
  logic [N_SW-1:0]  rise_d;
  logic [N_SW-1:0]  fall_d;

  // ---- stage p0/p1: two-flop synchroniser, only sync_p1 reaches the filter ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce next-state: one independent FSM per channel ----
  always_comb begin
    state_d = state_q;
    db_d    = sw_db;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (sync_p1[i] != sw_db[i]) begin
            if (DEB_CYCLES == 1) begin
              // A single disagreeing sample is already enough.
              db_d[i]   = sync_p1[i];
              rise_d[i] = sync_p1[i];
              fall_d[i] = ~sync_p1[i];
            end else begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        default: begin
          if (sync_p1[i] == sw_db[i]) begin
            // Glitch: input went back before the window filled.
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
            db_d[i]    = sync_p1[i];
            rise_d[i]  = sync_p1[i];
            fall_d[i]  = ~sync_p1[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
  end

  // ---- stage p2: filter state, clean level and edge pulses ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      sw_any  <= 1'b0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sw_db   <= db_d;
      sw_rise <= rise_d;
      sw_fall <= fall_d;
      // sw_any comes from the same next-state terms so it lines up with the pulses.
      sw_any  <= |(rise_d | fall_d);
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef SW_EVENT_LATCH_EN
  // ---- stage p3: sticky event flags, set has priority over clear ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_evt <= '0;
    end else begin
      sw_evt <= (sw_evt & ~evt_clr) | sw_rise | sw_fall;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//  Bench for sw_debounce with N_SW=2, DEB_CYCLES=4, CNT_W=3. A table of
//  per-cycle vectors covers reset and basic accept timing, hand sequences
//  cover bounce, short pulses and reset mid-debounce, and a randomized phase
//  runs against a sliding-window reference model that is compared every cycle.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

  localparam int NSW = 2;
  localparam int DEB = 4;
  localparam int CW  = 3;

  logic           clk;
  logic           rst_n;
  logic [NSW-1:0] sw;
  logic [NSW-1:0] sw_db;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] sw_fall;
  logic           sw_any;
`ifdef SW_EVENT_LATCH_EN
  logic [NSW-1:0] evt_clr;
  logic [NSW-1:0] sw_evt;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  sw_debounce #(
    .N_SW      (NSW),
    .DEB_CYCLES(DEB),
    .CNT_W     (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_any (sw_any)
`ifdef SW_EVENT_LATCH_EN
    ,
    .evt_clr(evt_clr),
    .sw_evt (sw_evt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a change is accepted when the last DEB synchronised
  // samples taken since reset all differ from the current clean level.
  logic [NSW-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_evt;
  logic           m_any;
  logic [DEB-1:0] win [NSW];
  int             nval [NSW];

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0; m_evt = '0;
      for (int c = 0; c < NSW; c++) begin
        win[c]  = '0;
        nval[c] = 0;
      end
    end else begin
`ifdef SW_EVENT_LATCH_EN
      m_evt = (m_evt & ~evt_clr) | m_rise | m_fall;
`endif
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < NSW; c++) begin
        win[c] = {win[c][DEB-2:0], m_s2[c]};
        if (nval[c] < DEB) nval[c]++;
        if (nval[c] == DEB && win[c] == {DEB{~m_db[c]}}) begin
          m_db[c]   = m_s2[c];
          m_rise[c] = m_s2[c];
          m_fall[c] = ~m_s2[c];
        end
      end
      m_any = |(m_rise | m_fall);
      m_s2  = m_s1;
      m_s1  = sw;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({sw_db, sw_rise, sw_fall, sw_any} !== {m_db, m_rise, m_fall, m_any}) begin
        errors++;
        $display("FAIL model t=%0t: db/rise/fall/any got %b/%b/%b/%b expected %b/%b/%b/%b",
                 $time, sw_db, sw_rise, sw_fall, sw_any, m_db, m_rise, m_fall, m_any);
      end
`ifdef SW_EVENT_LATCH_EN
      checks++;
      if (sw_evt !== m_evt) begin
        errors++;
        $display("FAIL model_evt t=%0t: got %b expected %b", $time, sw_evt, m_evt);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold sw for n cycles, requiring a fixed clean level and no pulses.
  task automatic quiet(input string name, input logic [1:0] v, input int n, input logic [1:0] exp_db);
    for (int k = 0; k < n; k++) begin
      sw = v;
      tick();
      chk(name, {25'd0, sw_db, sw_rise, sw_fall, sw_any}, {25'd0, exp_db, 2'b00, 2'b00, 1'b0});
    end
  endtask

  task automatic settle(input logic [1:0] v);
    sw = v;
    repeat (9) tick();
  endtask

  typedef struct packed {
    logic       rst_n;
    logic [1:0] sw;
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       any;
  } vec_t;

  vec_t tbl [24];

  initial begin
    // Vectors: reset with switches high, accept at 6th edge, then a fall and a rise on bit 0.
    for (int k = 0; k < 24; k++) begin
      tbl[k].rst_n = (k >= 3);
      tbl[k].sw    = (k < 10) ? 2'b11 : (k < 17) ? 2'b10 : 2'b11;
      tbl[k].db    = (k < 8) ? 2'b00 : (k < 15) ? 2'b11 : (k < 22) ? 2'b10 : 2'b11;
      tbl[k].rise  = 2'b00;
      tbl[k].fall  = 2'b00;
      tbl[k].any   = 1'b0;
    end
    tbl[8].rise  = 2'b11; tbl[8].any  = 1'b1;
    tbl[15].fall = 2'b01; tbl[15].any = 1'b1;
    tbl[22].rise = 2'b01; tbl[22].any = 1'b1;

    rst_n = 1'b0;
    sw    = 2'b11;
`ifdef SW_EVENT_LATCH_EN
    evt_clr = 2'b00;
`endif

    for (int k = 0; k < 24; k++) begin
      rst_n = tbl[k].rst_n;
      sw    = tbl[k].sw;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", k), {25'd0, sw_db, sw_rise, sw_fall, sw_any},
          {25'd0, tbl[k].db, tbl[k].rise, tbl[k].fall, tbl[k].any});
    end

    // Bounce on bit 0: 3-cycle segments never reach the window.
    settle(2'b10);
    chk("bounce_pre", {30'd0, sw_db}, {30'd0, 2'b10});
    quiet("bounce1", 2'b11, 3, 2'b10);
    quiet("bounce0", 2'b10, 3, 2'b10);
    quiet("bounce1b", 2'b11, 3, 2'b10);
    quiet("bounce0b", 2'b10, 3, 2'b10);
    quiet("bounce_hold", 2'b11, 5, 2'b10);
    tick();
    chk("bounce_accept", {25'd0, sw_db, sw_rise, sw_fall, sw_any}, {25'd0, 2'b11, 2'b01, 2'b00, 1'b1});
    quiet("bounce_after", 2'b11, 1, 2'b11);

    // Bit 1 high for DEB-1 cycles is rejected, for DEB cycles is accepted.
    settle(2'b01);
    quiet("short3", 2'b11, 3, 2'b01);
    quiet("short3_after", 2'b01, 6, 2'b01);
    quiet("exact4", 2'b11, 4, 2'b01);
    quiet("exact4_wait", 2'b01, 1, 2'b01);
    sw = 2'b01;
    tick();
    chk("exact4_accept", {25'd0, sw_db, sw_rise, sw_fall, sw_any}, {25'd0, 2'b11, 2'b10, 2'b00, 1'b1});

    // Reset with a change pending discards the count.
    settle(2'b00);
    quiet("pend", 2'b01, 4, 2'b00);
    rst_n = 1'b0;
    tick();
    chk("rst_mid", {25'd0, sw_db, sw_rise, sw_fall, sw_any}, 32'd0);
    tick();
    rst_n = 1'b1;
    quiet("rst_redeb", 2'b01, 5, 2'b00);
    tick();
    chk("rst_accept", {25'd0, sw_db, sw_rise, sw_fall, sw_any}, {25'd0, 2'b01, 2'b01, 2'b00, 1'b1});

`ifdef SW_EVENT_LATCH_EN
    // Sticky flags: set wins over a coincident clear; bit 0 stays as it was.
    settle(2'b11);
    evt_clr = 2'b10;
    tick();
    evt_clr = 2'b00;
    chk("evt_clr1", {30'd0, sw_evt}, {30'd0, 2'b01});
    quiet("evt_fallwait", 2'b01, 5, 2'b11);
    tick();
    chk("evt_fall", {25'd0, sw_db, sw_rise, sw_fall, sw_any}, {25'd0, 2'b01, 2'b00, 2'b10, 1'b1});
    evt_clr = 2'b10;
    tick();
    evt_clr = 2'b00;
    chk("evt_setwins", {30'd0, sw_evt}, {30'd0, 2'b11});
    tick();
    chk("evt_hold", {30'd0, sw_evt}, {30'd0, 2'b11});
    evt_clr = 2'b10;
    tick();
    evt_clr = 2'b00;
    chk("evt_clr2", {30'd0, sw_evt}, {30'd0, 2'b01});
`endif

    // Randomized phase, checked every cycle by the model.
    for (int seg = 0; seg < 80; seg++) begin
      sw = 2'($urandom);
      if ($urandom_range(0, 19) == 0) rst_n = 1'b0;
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
`ifdef SW_EVENT_LATCH_EN
        evt_clr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
`endif
        tick();
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
